modexp_sequencer: RTL and testbench

- Multi-cycle execute-stage unit for the two long-latency ALU operations of the RSA pipeline CPU: MOD (ALUControl 3'b101) and EXP (ALUControl 3'b110, modular exponentiation).
- Accepts an operation from the EX stage and stalls the pipeline while it runs.
- Sequences one shared serial modular multiplier through square-and-multiply, then returns a WIDTH-bit result with a one-cycle done pulse.

---
 rtl/rsa_alu_pkg.sv | 17 +
 rtl/mulmod_serial.sv | 68 ++++++
 rtl/modexp_sequencer.sv | 151 +++++++++++++++
 tb/tb_modexp_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rsa_alu_pkg.sv
// rsa_alu_pkg: ALU op encodings and sequencer state type shared by the
// long-latency MOD/EXP execute unit.
`timescale 1ns/1ps
package rsa_alu_pkg;

  localparam logic [2:0] ALU_MOD = 3'b101;
  localparam logic [2:0] ALU_EXP = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    SQUARE,
    MULT,
    FINISH
  } modexp_state_t;

endpackage

// File: rtl/mulmod_serial.sv
// mulmod_serial: interleaved shift-add modular multiplier, p = x*y mod n.
// Requires y <= n and n != 0; done pulses WIDTH cycles after go.
`timescale 1ns/1ps
module mulmod_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] xs, ys, ns, pq;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] cur_x, cur_y, cur_n, cur_p;
  logic [WIDTH:0]   dbl, acc;
  logic [WIDTH-1:0] dbl_r, p_next;

  // The first iteration runs on the go edge straight from the inputs, so the
  // last one lands WIDTH cycles later and its result is already in pq.
  always_comb begin
    cur_x  = go ? x : xs;
    cur_y  = go ? y : ys;
    cur_n  = go ? n : ns;
    cur_p  = go ? '0 : pq;
    dbl    = {cur_p, 1'b0};
    dbl_r  = (dbl >= {1'b0, cur_n}) ? WIDTH'(dbl - {1'b0, cur_n}) : dbl[WIDTH-1:0];
    acc    = {1'b0, dbl_r} + (cur_x[WIDTH-1] ? {1'b0, cur_y} : '0);
    p_next = (acc >= {1'b0, cur_n}) ? WIDTH'(acc - {1'b0, cur_n}) : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs   <= '0;
      ys   <= '0;
      ns   <= '0;
      pq   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (go) begin
      xs   <= {x[WIDTH-2:0], 1'b0};
      ys   <= y;
      ns   <= n;
      pq   <= p_next;
      cnt  <= CW'(WIDTH - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        xs  <= {xs[WIDTH-2:0], 1'b0};
        pq  <= p_next;
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign done = busy && (cnt == '0);
  assign p    = pq;

endmodule

// File: rtl/modexp_sequencer.sv
// modexp_sequencer: multi-cycle MOD / EXP unit for the RSA pipeline EX stage.
// Optional define MODEXP_SKIP_LZ_EN starts the exponent scan at e's top set bit.
`timescale 1ns/1ps
module modexp_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] n,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  import rsa_alu_pkg::*;

  localparam int PW = $clog2(WIDTH);

  modexp_state_t    state, state_nx;
  logic             valid_op, accept, go, mm_busy, mm_done;
  logic [WIDTH-1:0] mm_x, mm_y, mm_p;
  logic [WIDTH-1:0] a_q, e_q, n_q, b_q, r_q, r_init;
  logic             is_exp, scan_none, scan_none_init;
  logic [PW-1:0]    ptr, ptr_init;

  assign valid_op = (op == ALU_MOD) || (op == ALU_EXP);
  assign accept   = (state == IDLE) && start && valid_op;
  assign stall    = busy || (start && valid_op);
  assign r_init   = (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);

`ifdef MODEXP_SKIP_LZ_EN
  always_comb begin
    ptr_init = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (e[i]) ptr_init = PW'(i);
    end
  end
  assign scan_none_init = (e == '0);
`else
  assign ptr_init       = PW'(WIDTH - 1);
  assign scan_none_init = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Each multiplier phase issues go on its first cycle and advances on mm_done.
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    mm_x     = r_q;
    mm_y     = r_q;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nx = (n == '0) ? FINISH : REDUCE;
      end
      REDUCE: begin
        go   = !mm_busy;
        mm_x = a_q;
        mm_y = WIDTH'(1);
        if (mm_done) state_nx = (!is_exp || scan_none) ? FINISH : SQUARE;
      end
      SQUARE: begin
        go = !mm_busy;
        if (mm_done) state_nx = e_q[ptr] ? MULT : ((ptr == '0) ? FINISH : SQUARE);
      end
      MULT: begin
        go   = !mm_busy;
        mm_y = b_q;
        if (mm_done) state_nx = (ptr == '0) ? FINISH : SQUARE;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // result is written only on the edge into FINISH so it is valid with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      e_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      is_exp    <= 1'b0;
      scan_none <= 1'b0;
      ptr       <= '0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q       <= a;
          e_q       <= e;
          n_q       <= n;
          is_exp    <= (op == ALU_EXP);
          err       <= (n == '0);
          ptr       <= ptr_init;
          scan_none <= scan_none_init;
          if (n == '0) result <= '0;
        end
        REDUCE: if (mm_done) begin
          b_q <= mm_p;
          r_q <= r_init;
          if (!is_exp)        result <= mm_p;
          else if (scan_none) result <= r_init;
        end
        SQUARE: if (mm_done) begin
          r_q <= mm_p;
          if (!e_q[ptr]) begin
            if (ptr == '0) result <= mm_p;
            else           ptr    <= ptr - PW'(1);
          end
        end
        MULT: if (mm_done) begin
          r_q <= mm_p;
          if (ptr == '0) result <= mm_p;
          else           ptr    <= ptr - PW'(1);
        end
        default: ;
      endcase
    end
  end

  mulmod_serial #(.WIDTH(WIDTH)) u_mulmod (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .x     (mm_x),
    .y     (mm_y),
    .n     (n_q),
    .busy  (mm_busy),
    .done  (mm_done),
    .p     (mm_p)
  );

endmodule

// File: tb/tb_modexp_sequencer.sv
// tb_modexp_sequencer: randomized self-checking bench for modexp_sequencer (WIDTH=8)
// against an arithmetic reference of MOD / modular exponentiation and latency.
`timescale 1ns/1ps
module tb_modexp_sequencer;
  import rsa_alu_pkg::*;

  localparam int W = 8;
`ifdef MODEXP_SKIP_LZ_EN
  localparam int LAT_EXP_3_5 = 55;
  localparam int LAT_EXP_E0  = 10;
`else
  localparam int LAT_EXP_3_5 = 100;
  localparam int LAT_EXP_E0  = 82;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, e = '0, n = '0;
  logic         stall, busy, done, err;
  logic [W-1:0] result;
  int total = 0, bad = 0;

  modexp_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .e(e), .n(n),
    .stall(stall), .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic, repeated multiplication for the power.
  function automatic int ref_res(bit is_exp, int av, int ev, int nv);
    longint r;
    if (nv == 0) return 0;
    if (!is_exp) return av % nv;
    r = 1 % nv;
    for (int i = 0; i < ev; i++) r = (r * av) % nv;
    return int'(r);
  endfunction

  function automatic int ref_lat(bit is_exp, int ev, int nv);
    int k, ones;
    if (nv == 0) return 1;
    if (!is_exp) return W + 2;
`ifdef MODEXP_SKIP_LZ_EN
    k = 0;
    while (k < W && (ev >> k) != 0) k++;
`else
    k = W;
`endif
    ones = 0;
    for (int i = 0; i < W; i++) ones += (ev >> i) & 1;
    return (W + 1) * (1 + k + ones) + 1;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, ev, nv, input bit hold,
                        output int lat, output logic [W-1:0] res, output logic er,
                        output logic er_first, output logic stall_ok, output logic pulse_ok);
    lat = -1; res = 'x; er = 1'bx; er_first = 1'bx; pulse_ok = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 500 && busy === 1'b1; g++) @(negedge clk);
    start = 1'b1; op = o; a = av; e = ev; n = nv;
    #1 stall_ok = (stall === 1'b1);
    @(posedge clk); #1;
    start = hold;
    for (int c = 1; c <= 600; c++) begin
      if (c == 1) er_first = err;
      if (done === 1'b1) begin
        lat = c; res = result; er = err;
        break;
      end
      if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      a = W'($urandom); e = W'($urandom); n = W'($urandom);
      if (hold) op = ($urandom_range(0, 1) == 1) ? ALU_MOD : ALU_EXP;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    pulse_ok = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({busy, done, err, stall} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {busy, done, err, stall}); end
    total++; if (result !== '0) begin bad++; $display("[TB] FAIL reset_result got=%0d want=0", result); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_mod;
    int lat; logic [W-1:0] res; logic er, ef, so, po;
    run_op(ALU_MOD, 8'd200, 8'd0, 8'd7, 1'b0, lat, res, er, ef, so, po);
    total++; if (res !== 8'd4) begin bad++; $display("[TB] FAIL mod_result got=%0d want=4", res); end
    total++; if (er !== 1'b0) begin bad++; $display("[TB] FAIL mod_err got=%b want=0", er); end
    total++; if (lat != W + 2) begin bad++; $display("[TB] FAIL mod_latency got=%0d want=%0d", lat, W + 2); end
    total++; if (so !== 1'b1) begin bad++; $display("[TB] FAIL mod_stall got=%b want=1", so); end
    total++; if (po !== 1'b1) begin bad++; $display("[TB] FAIL mod_done_pulse got=%b want=1", po); end
  endtask

  task automatic test_exp;
    int lat; logic [W-1:0] res; logic er, ef, so, po;
    run_op(ALU_EXP, 8'd3, 8'd5, 8'd7, 1'b0, lat, res, er, ef, so, po);
    total++; if (res !== 8'd5) begin bad++; $display("[TB] FAIL exp_result got=%0d want=5", res); end
    total++; if (lat != LAT_EXP_3_5) begin bad++; $display("[TB] FAIL exp_latency got=%0d want=%0d", lat, LAT_EXP_3_5); end
    total++; if (so !== 1'b1 || po !== 1'b1) begin bad++; $display("[TB] FAIL exp_stall_pulse got=%b%b want=11", so, po); end
    run_op(ALU_EXP, 8'd9, 8'd0, 8'd7, 1'b0, lat, res, er, ef, so, po);
    total++; if (res !== 8'd1) begin bad++; $display("[TB] FAIL exp_e0_result got=%0d want=1", res); end
    total++; if (lat != LAT_EXP_E0) begin bad++; $display("[TB] FAIL exp_e0_latency got=%0d want=%0d", lat, LAT_EXP_E0); end
    run_op(ALU_EXP, 8'd5, 8'd3, 8'd1, 1'b0, lat, res, er, ef, so, po);
    total++; if (res !== 8'd0) begin bad++; $display("[TB] FAIL exp_n1_result got=%0d want=0", res); end
    total++; if (lat != ref_lat(1'b1, 3, 1)) begin bad++; $display("[TB] FAIL exp_n1_latency got=%0d want=%0d", lat, ref_lat(1'b1, 3, 1)); end
  endtask

  task automatic test_zero_modulus;
    int lat; logic [W-1:0] res; logic er, ef, so, po;
    run_op(ALU_MOD, 8'd77, 8'd0, 8'd13, 1'b0, lat, res, er, ef, so, po);
    for (int t = 0; t < 2; t++) begin
      run_op(t == 0 ? ALU_MOD : ALU_EXP, 8'd77, 8'd4, 8'd0, 1'b0, lat, res, er, ef, so, po);
      total++; if (res !== 8'd0 || er !== 1'b1) begin bad++; $display("[TB] FAIL nzero_result_err t=%0d got=%0d/%b want=0/1", t, res, er); end
      total++; if (lat != 1) begin bad++; $display("[TB] FAIL nzero_latency t=%0d got=%0d want=1", t, lat); end
    end
    run_op(ALU_MOD, 8'd50, 8'd0, 8'd9, 1'b0, lat, res, er, ef, so, po);
    total++; if (ef !== 1'b0 || er !== 1'b0) begin bad++; $display("[TB] FAIL nzero_err_clear got=%b/%b want=0/0", ef, er); end
    total++; if (res !== 8'd5) begin bad++; $display("[TB] FAIL nzero_next_result got=%0d want=5", res); end
  endtask

  task automatic test_ignored;
    int lat; logic [W-1:0] res; logic er, ef, so, po;
    logic seen;
    logic [2:0] bad_ops [2];
    bad_ops[0] = 3'b000; bad_ops[1] = 3'b111;
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); start = 1'b1; op = bad_ops[k]; a = 8'd1; e = 8'd1; n = 8'd3;
      repeat (4) begin
        #1 if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
        @(negedge clk);
      end
      start = 1'b0;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL invalid_op_accepted got=%b want=0", seen); end
    total++; if (result !== 8'd5) begin bad++; $display("[TB] FAIL invalid_op_result got=%0d want=5", result); end
    run_op(ALU_EXP, 8'd3, 8'd5, 8'd7, 1'b1, lat, res, er, ef, so, po);
    total++; if (res !== 8'd5 || lat != LAT_EXP_3_5) begin bad++; $display("[TB] FAIL busy_start got=%0d/%0d want=5/%0d", res, lat, LAT_EXP_3_5); end
    total++; if (po !== 1'b1) begin bad++; $display("[TB] FAIL busy_start_reaccept got=%b want=1", po); end
  endtask

  task automatic test_random;
    int lat, el, er_exp; logic [W-1:0] res; logic er, ef, so, po;
    bit x; int av, ev, nv, want;
    for (int i = 0; i < 24; i++) begin
      x  = 1'($urandom_range(0, 1));
      av = $urandom_range(0, 255);
      ev = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      nv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      want = ref_res(x, av, ev, nv);
      el = ref_lat(x, ev, nv);
      er_exp = (nv == 0) ? 1 : 0;
      run_op(x ? ALU_EXP : ALU_MOD, W'(av), W'(ev), W'(nv), 1'b0, lat, res, er, ef, so, po);
      total++; if (res !== W'(want)) begin bad++; $display("[TB] FAIL rand_result i=%0d exp=%0d a=%0d e=%0d n=%0d got=%0d want=%0d", i, x, av, ev, nv, res, want); end
      total++; if (er !== 1'(er_exp)) begin bad++; $display("[TB] FAIL rand_err i=%0d got=%b want=%0d", i, er, er_exp); end
      total++; if (lat != el) begin bad++; $display("[TB] FAIL rand_latency i=%0d got=%0d want=%0d", i, lat, el); end
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [W-1:0] res; logic er, ef, so, po;
    logic seen;
    run_op(ALU_EXP, 8'd3, 8'd5, 8'd7, 1'b0, lat, res, er, ef, so, po);
    @(negedge clk); start = 1'b1; op = ALU_EXP; a = 8'd123; e = 8'hff; n = 8'd251;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, err, stall} !== 4'b0000) begin bad++; $display("[TB] FAIL midreset_flags got=%b want=0000", {busy, done, err, stall}); end
    total++; if (result !== '0) begin bad++; $display("[TB] FAIL midreset_result got=%0d want=0", result); end
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1 if (done !== 1'b0) seen = 1'b1; end
    @(negedge clk) rst_n = 1'b1;
    repeat (200) begin @(posedge clk); #1 if (done !== 1'b0) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL midreset_done_seen got=%b want=0", seen); end
    run_op(ALU_MOD, 8'd200, 8'd0, 8'd13, 1'b0, lat, res, er, ef, so, po);
    total++; if (res !== 8'd5 || lat != W + 2) begin bad++; $display("[TB] FAIL midreset_mod got=%0d/%0d want=5/%0d", res, lat, W + 2); end
  endtask

  initial begin
    test_reset();
    test_mod();
    test_exp();
    test_zero_modulus();
    test_ignored();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
